// File: rtl/rb_mul_sequencer.sv
// ============================================================================
// Module   : rb_mul_sequencer
// Purpose  : Executes rd <= rs * rt on a 16x32 register bank using an
//            external multiplier. It reads both operands, launches the
//            multiplier, waits for completion with a timeout, and writes the
//            64-bit product back to rd (low word) and rd+1 (high word).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rb_mul_sequencer #(
    parameter int TIMEOUT  = 64,
    parameter bit WRITE_HI = 1'b1
) (
    input  logic        clk,
    input  logic        reset_all,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_rs,
    input  logic [3:0]  cmd_rt,
    input  logic [3:0]  cmd_rd,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic        busy,
    output logic [3:0]  rb_rs,
    output logic [3:0]  rb_rt,
    output logic [3:0]  rb_rd,
    output logic        rb_read,
    output logic        rb_write,
    output logic        rb_enable,
    output logic [31:0] rb_in,
    input  logic [31:0] rb_out1,
    input  logic [31:0] rb_out2,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_product
);

    localparam int             c_CW   = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_WR_LO  = 3'd4,
        S_WR_HI  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [31:0]       r_prod_hi;

    // Outputs are registered: each transition loads the Moore outputs of the
    // state being entered, so they always match the current state register.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prod_hi <= '0;
            cmd_ready <= 1'b1;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            busy      <= 1'b0;
            rb_rs     <= '0;
            rb_rt     <= '0;
            rb_rd     <= '0;
            rb_read   <= 1'b0;
            rb_write  <= 1'b0;
            rb_enable <= 1'b0;
            rb_in     <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            rb_read   <= 1'b0;
            rb_write  <= 1'b0;
            rb_enable <= 1'b0;
            mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rb_rs     <= cmd_rs;
                        rb_rt     <= cmd_rt;
                        rb_rd     <= cmd_rd;
                        rb_read   <= 1'b1;
                        rb_enable <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    mul_a     <= rb_out1;
                    mul_b     <= rb_out2;
                    mul_start <= 1'b1;
                    r_state   <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion in the final allowed cycle takes priority over abort.
                    if (mul_done) begin
                        r_prod_hi <= mul_product[63:32];
                        rb_in     <= mul_product[31:0];
                        rb_write  <= 1'b1;
                        rb_enable <= 1'b1;
                        r_state   <= S_WR_LO;
                    end else if (r_cnt == c_LAST) begin
                        cmd_err <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_LO: begin
                    if (WRITE_HI) begin
                        rb_rd     <= rb_rd + 4'd1;
                        rb_in     <= r_prod_hi;
                        rb_write  <= 1'b1;
                        rb_enable <= 1'b1;
                        r_state   <= S_WR_HI;
                    end else begin
                        cmd_done <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_WR_HI: begin
                    cmd_done <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE, S_ERR: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rb_mul_sequencer.sv
// ============================================================================
// Module   : tb_rb_mul_sequencer
// Purpose  : Randomized and directed bench for rb_mul_sequencer; unit 0 has
//            WRITE_HI=1, unit 1 has WRITE_HI=0, each with its own bank/multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rb_mul_sequencer;

    localparam int c_TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       cmd_valid;
    logic [3:0]       cmd_rs, cmd_rt, cmd_rd;
    logic [1:0]       cmd_ready, cmd_done, cmd_err, busy;
    logic [1:0][3:0]  rb_rs, rb_rt, rb_rd;
    logic [1:0]       rb_read, rb_write, rb_enable, mul_start, mul_done;
    logic [1:0][31:0] rb_in, rb_out1, rb_out2, mul_a, mul_b;
    logic [1:0][63:0] mul_product;

    logic [31:0] bank     [2][16];
    logic [31:0] ref_bank [2][16];
    int          lat  [2];
    int          mcnt [2];
    logic [1:0]  mact;
    int          wcnt [2];
    int          ovl;
    logic        pre_we;
    int          pre_u;
    logic [3:0]  pre_a;
    logic [31:0] pre_d;

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rb_mul_sequencer #(.TIMEOUT(c_TO), .WRITE_HI(g == 0)) u_dut (
            .clk(clk), .reset_all(rst),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
            .cmd_done(cmd_done[g]), .cmd_err(cmd_err[g]), .busy(busy[g]),
            .rb_rs(rb_rs[g]), .rb_rt(rb_rt[g]), .rb_rd(rb_rd[g]),
            .rb_read(rb_read[g]), .rb_write(rb_write[g]), .rb_enable(rb_enable[g]),
            .rb_in(rb_in[g]), .rb_out1(rb_out1[g]), .rb_out2(rb_out2[g]),
            .mul_start(mul_start[g]), .mul_a(mul_a[g]), .mul_b(mul_b[g]),
            .mul_done(mul_done[g]), .mul_product(mul_product[g])
        );
        assign mul_product[g] = $signed(mul_a[g]) * $signed(mul_b[g]);
        assign mul_done[g]    = mact[g] && (mcnt[g] == lat[g]);
    end

    // Bank and multiplier behaviour; lat==0 means the multiplier never finishes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 16; i++) bank[u][i] <= '0;
                mcnt[u] <= 0;
                wcnt[u] <= 0;
            end
            mact <= '0;
            ovl  <= 0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (rb_write[u] && rb_enable[u]) begin
                    bank[u][rb_rd[u]] <= rb_in[u];
                    wcnt[u] <= wcnt[u] + 1;
                end
                if (rb_read[u] && rb_write[u]) ovl <= ovl + 1;
                if (mul_start[u]) begin
                    mact[u] <= 1'b1;
                    mcnt[u] <= 1;
                end else if (mact[u]) begin
                    if (mul_done[u]) mact[u] <= 1'b0;
                    else mcnt[u] <= mcnt[u] + 1;
                end
            end
            if (pre_we) bank[pre_u][pre_a] <= pre_d;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rb_read[u] && rb_enable[u]) begin
                rb_out1[u] <= bank[u][rb_rs[u]];
                rb_out2[u] <= bank[u][rb_rt[u]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int u);
        check("idle_ready", cmd_ready[u], 1'b1);
        check("idle_busy", busy[u], 1'b0);
        check("idle_pulses", {cmd_done[u], cmd_err[u], mul_start[u]}, 3'b000);
        check("idle_ctl", {rb_read[u], rb_write[u], rb_enable[u]}, 3'b000);
        check("idle_addr", {rb_rs[u], rb_rt[u], rb_rd[u]}, 12'h000);
        check("idle_data", {rb_in[u], mul_a[u]}, 64'h0);
        check("idle_mulb", mul_b[u], 32'h0);
    endtask

    // Entered just after a negedge; asynchronous reset must take effect at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_idle(0);
        check_idle(1);
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 16; i++) ref_bank[u][i] = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_writes0", wcnt[0], 0);
        check("post_reset_writes1", wcnt[1], 0);
        check_idle(0);
    endtask

    task automatic load(input int u, input logic [3:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_u = u; pre_a = a; pre_d = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_bank[u][a] = d;
        @(negedge clk);
    endtask

    // Issues one command (caller sits just after a negedge) and checks
    // latency, operands and the resulting bank against the reference model.
    task automatic run_cmd(input int u, input logic [3:0] rs, input logic [3:0] rt,
                           input logic [3:0] rd, input int l, input bit keep,
                           input int pulse_at, input int abort_at);
        int          start_c, done_c, err_c, ready_c, exp_end, w0;
        bit          ok;
        logic [31:0] ea, eb;
        longint      sa, sb, p;
        ea = ref_bank[u][rs];
        eb = ref_bank[u][rt];
        lat[u] = l;
        w0 = wcnt[u];
        cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_valid[u] = 1'b1;
        check("ready_at_issue", cmd_ready[u], 1'b1);
        @(posedge clk);
        #1;
        if (!keep) cmd_valid[u] = 1'b0;
        start_c = 0; done_c = 0; err_c = 0; ready_c = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == abort_at) begin
                do_reset();
                return;
            end
            if (cyc == pulse_at) begin
                cmd_valid[u] = 1'b1;
                cmd_rs = ~rs; cmd_rt = ~rt; cmd_rd = ~rd;
                check("ready_while_busy", cmd_ready[u], 1'b0);
            end else if (cyc == pulse_at + 1) begin
                cmd_valid[u] = 1'b0;
            end
            if (mul_start[u]) begin
                start_c = cyc;
                check("mul_a", mul_a[u], ea);
                check("mul_b", mul_b[u], eb);
            end
            if (cmd_done[u]) done_c = cyc;
            if (cmd_err[u]) err_c = cyc;
            if (cmd_ready[u]) begin
                ready_c = cyc;
                break;
            end
        end
        ok = (l >= 1) && (l <= c_TO);
        exp_end = ok ? ((u == 0) ? 5 : 4) + l : 3 + c_TO;
        check("start_cycle", start_c, 2);
        check("done_cycle", done_c, ok ? exp_end : 0);
        check("err_cycle", err_c, ok ? 0 : exp_end);
        check("ready_cycle", ready_c, exp_end + 1);
        check("write_count", wcnt[u] - w0, ok ? ((u == 0) ? 2 : 1) : 0);
        if (ok) begin
            sa = $signed(ea);
            sb = $signed(eb);
            p  = sa * sb;
            ref_bank[u][rd] = p[31:0];
            if (u == 0) ref_bank[u][rd + 4'd1] = p[63:32];
        end
        for (int i = 0; i < 16; i++) check($sformatf("bank%0d_r%0d", u, i), bank[u][i], ref_bank[u][i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        cmd_valid = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        pre_we = 1'b0; pre_u = 0; pre_a = '0; pre_d = '0;
        lat[0] = 1; lat[1] = 1;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 16; i++) ref_bank[u][i] = '0;
        repeat (2) @(negedge clk);
        check_idle(0);
        check_idle(1);
        rst = 1'b0;
        @(negedge clk);

        // Basic signed multiply, done in first WAIT cycle.
        load(0, 4'd1, 32'd7);
        load(0, 4'd2, 32'hFFFF_FFFD);
        run_cmd(0, 4'd1, 4'd2, 4'd3, 1, 1'b0, 0, 0);
        check("r3_value", bank[0][3], 32'hFFFF_FFEB);
        check("r4_value", bank[0][4], 32'hFFFF_FFFF);

        // rd=15 wraps the high-word write to R0; low-word-only variant.
        for (int u = 0; u < 2; u++) begin
            load(u, 4'd1, 32'h0001_0000);
            load(u, 4'd2, 32'h0001_0000);
            load(u, 4'd0, 32'h55);
            run_cmd(u, 4'd1, 4'd2, 4'd15, 1, 1'b0, 0, 0);
        end
        check("wrap_r0", bank[0][0], 32'd1);
        check("nowrap_r0", bank[1][0], 32'h55);

        // Timeout and done in the last allowed cycle.
        load(0, 4'd9, 32'hDEAD_BEEF);
        run_cmd(0, 4'd1, 4'd2, 4'd9, 0, 1'b0, 0, 0);
        run_cmd(0, 4'd1, 4'd3, 4'd9, c_TO, 1'b0, 0, 0);
        run_cmd(1, 4'd1, 4'd2, 4'd7, 0, 1'b0, 0, 0);

        // Valid pulsed during WAIT is ignored; held valid accepted on return to idle.
        run_cmd(0, 4'd3, 4'd1, 4'd8, 3, 1'b0, 4, 0);
        run_cmd(0, 4'd1, 4'd2, 4'd10, 1, 1'b1, 0, 0);
        run_cmd(0, 4'd10, 4'd1, 4'd12, 2, 1'b0, 0, 0);

        // Reset mid-WAIT and mid-WR_LO, then normal operation.
        load(0, 4'd5, 32'h0001_0000);
        run_cmd(0, 4'd5, 4'd5, 4'd6, 5, 1'b0, 0, 4);
        load(0, 4'd5, 32'h0001_0000);
        run_cmd(0, 4'd5, 4'd5, 4'd6, 1, 1'b0, 0, 4);
        load(0, 4'd5, 32'h0001_0000);
        run_cmd(0, 4'd5, 4'd5, 4'd5, 1, 1'b0, 0, 0);
        check("alias_r5", bank[0][5], 32'h0);
        check("alias_r6", bank[0][6], 32'h1);

        // Randomized commands.
        for (int k = 0; k < 24; k++) begin
            int          u, l;
            logic [3:0]  rs, rt, rd;
            u  = int'($urandom_range(0, 1));
            rs = 4'($urandom);
            rt = 4'($urandom);
            rd = 4'($urandom);
            l  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            load(u, rs, $urandom);
            if ($urandom_range(0, 1) == 1) load(u, rt, $urandom);
            run_cmd(u, rs, rt, rd, l, 1'b0, 0, 0);
        end

        check("read_write_overlap", ovl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rb_mul_sequencer.md
# rb_mul_sequencer

Controller that executes one register-to-register multiply on the 16×32 register bank. It accepts a command naming source registers rs/rt and destination rd, and reads both operands through the bank's read port. It then launches the Booth multiplier and waits for completion (with timeout), and writes the 64-bit product back as low word to rd and high word to rd+1. It sits between the instruction/command source and the register bank plus multiplier pair, and owns the bank's control pins while busy.

## Interface
- TIMEOUT, 64, maximum number of WAIT cycles before abort (≥1)
- WRITE_HI, 1, 1 = also write product[63:32] to rd+1; 0 = low word only
- clk  in  1  single clock; all state on posedge
- reset_all  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at posedge
- cmd_rs, cmd_rt, cmd_rd  in  4 each  register indices, captured on accept
- cmd_done  out  1  one-cycle pulse: write-back complete
- cmd_err  out  1  one-cycle pulse: multiplier timeout, nothing written
- busy  out  1  state ≠ IDLE
- rb_rs, rb_rt, rb_rd  out  4 each  bank address pins (registered command fields)
- rb_read, rb_write, rb_enable  out  1 each  bank control
- rb_in  out  32  bank write data
- rb_out1, rb_out2  in  32 each  bank read data (bank updates them on negedge when read&enable)
- mul_start  out  1  one-cycle launch pulse
- mul_a, mul_b  out  32 each  operands (held stable from LAUNCH until next accept)
- mul_done  in  1  multiplier completion; product valid in the same cycle
- mul_product  in  64  signed product

## Operation
- States: IDLE, RD, LAUNCH, WAIT, WR_LO, WR_HI, DONE, ERR. Moore outputs decoded from the state register only.
- IDLE: cmd_ready=1. On accept, register rs/rt/rd → RD.
- RD: rb_read=1, rb_enable=1; bank latches R[rs], R[rt] at mid-cycle negedge. At exit edge capture rb_out1→mul_a, rb_out2→mul_b → LAUNCH.
- LAUNCH: mul_start=1 → WAIT; clear timeout counter. mul_done here is ignored (multiplier contract: done ≥1 cycle after start).
- WAIT: if mul_done → capture mul_product into product register, → WR_LO. Else increment counter; if the TIMEOUT-th WAIT cycle passes without done → ERR. Done in the TIMEOUT-th cycle wins over timeout.
- WR_LO: rb_write=1, rb_enable=1, rb_rd=rd, rb_in=product[31:0]. Next WR_HI if WRITE_HI else DONE.
- WR_HI: rb_write=1, rb_enable=1, rb_rd=(rd+1) mod 16 (15 wraps to 0), rb_in=product[63:32] → DONE.
- DONE: cmd_done=1 → IDLE. ERR: cmd_err=1 → IDLE.
- rb_read and rb_write are never high in the same cycle; rb_enable = rb_read | rb_write.
- cmd_valid while busy: ignored, no queueing; requester holds valid until ready.
- rd equal to rs or rt permitted (operands already captured).
- Reset (any state): immediately IDLE; cmd_ready=1, busy=0; every other output 0 (including rb_* addresses/data, mul_a/b, product, counter). No bank write is issued after reset asserts. reset_all also clears bank contents externally.

## Timing
- Cycle n = interval after accept edge E0 plus n−1 edges. RD = cycle 1, LAUNCH = 2, first WAIT = 3.
- mul_done in first WAIT cycle: WR_LO = 4, WR_HI = 5, cmd_done = 6, cmd_ready back in cycle 7 (WRITE_HI=0: cmd_done in 5, ready in 6).
- Multiplier latency L WAIT cycles (done in the L-th) adds L−1 cycles to the above.
- Bank writes commit at the posedge ending WR_LO / WR_HI.
- Timeout: no done → cmd_err in cycle 3+TIMEOUT, ready in cycle 4+TIMEOUT.
- Back-to-back commands: minimum spacing 7 cycles (WRITE_HI=1, L=1).

## Test plan
- R1=7, R2=0xFFFFFFFD, cmd rs=1 rt=2 rd=3, done in first WAIT -> mul_a=7, mul_b=−3; R3=0xFFFFFFEB, R4=0xFFFFFFFF; cmd_done in cycle 6.
- rd=15, product 0x00000001_00000000 -> R15=0, R0=1 (wrap); WRITE_HI=0 run leaves R0 unchanged, cmd_done in cycle 5.
- TIMEOUT=64, mul_done never asserted -> cmd_err pulse in cycle 67, rb_write never high, R[rd] unchanged; done in 64th WAIT cycle instead -> normal write, no err.
- Second cmd_valid pulsed during WAIT -> ignored (cmd_ready=0), only first command's registers written; held valid is accepted in cycle 7.
- reset_all asserted mid-WAIT and mid-WR_LO -> same-cycle IDLE, all outputs 0, cmd_ready=1, no subsequent rb_write; next command runs normally.
- rs=rt=rd=5, R5=0x00010000 -> R5=0, R6=1.
